// File: rtl/xdump_ctrl.sv
// xdump_ctrl: run/dump controller for a processor register file.
//
// Purpose:
//   After a start pulse the block counts RUN cycles until the processor traps
//   (or an optional watchdog fires). It then walks the register file, one word
//   per two cycles (RD: present address, OUT: offer word), streaming
//   {index, value} pairs over a valid/ready port, and parks in DONE.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous reset, active low
//   start      - one-cycle pulse, begins a run from IDLE or DONE
//   trap       - processor end-of-program indication (sampled in RUN only)
//   regf_addr  - register-file read address (always equals the dump index)
//   regf_rdata - register-file read data, valid one cycle after regf_addr
//   dump_valid - a dump word is offered
//   dump_ready - sink accepts the offered word
//   dump_addr  - register index of the offered word
//   dump_data  - register value of the offered word
//   cycles     - RUN cycles elapsed, saturating
//   busy       - high in RUN, RD and OUT
//   done       - high in DONE
//   timeout    - sticky: the last run was ended by the watchdog
module xdump_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REGF_ADDR_W = 4,
  parameter int CYC_W       = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   trap,
  output logic [REGF_ADDR_W-1:0] regf_addr,
  input  logic [DATA_W-1:0]      regf_rdata,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [REGF_ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0]      dump_data,
  output logic [CYC_W-1:0]       cycles,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_RD   = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic                   WD_EN    = (TIMEOUT > 0);
  // Last count value before the watchdog trips; only meaningful when WD_EN.
  localparam logic [CYC_W-1:0]       WD_LAST  = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0]       CYC_MAX  = '1;
  localparam logic [REGF_ADDR_W-1:0] IDX_LAST = '1;

  state_t                 r_state;
  logic [REGF_ADDR_W-1:0] r_index;
  logic [CYC_W-1:0]       r_cycles;
  logic                   r_timeout;
  logic [REGF_ADDR_W-1:0] r_dump_addr;
  logic [DATA_W-1:0]      r_dump_data;
  logic                   r_dump_valid;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state_nxt;
  logic [REGF_ADDR_W-1:0] w_index_nxt;
  logic [CYC_W-1:0]       w_cycles_nxt;
  logic                   w_timeout_nxt;
  logic [REGF_ADDR_W-1:0] w_dump_addr_nxt;
  logic [DATA_W-1:0]      w_dump_data_nxt;
  logic [CYC_W-1:0]       w_cycles_inc;
  logic                   w_wd_hit;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_cycles_inc = (r_cycles == CYC_MAX) ? r_cycles : (r_cycles + CYC_W'(1));
  assign w_wd_hit     = WD_EN && (r_cycles == WD_LAST);

  // Next-state and datapath next values; everything holds unless a branch updates it.
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_cycles_nxt    = r_cycles;
    w_timeout_nxt   = r_timeout;
    w_dump_addr_nxt = r_dump_addr;
    w_dump_data_nxt = r_dump_data;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_index_nxt   = '0;
          w_cycles_nxt  = '0;
          w_timeout_nxt = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        // Trap has priority over a coinciding watchdog expiry; the trap
        // cycle itself is not counted.
        if (trap) begin
          w_state_nxt = S_RD;
          w_index_nxt = '0;
        end else if (w_wd_hit) begin
          w_state_nxt   = S_RD;
          w_index_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_cycles_nxt  = w_cycles_inc;
        end else begin
          w_cycles_nxt = w_cycles_inc;
        end
      end
      S_RD: begin
        // regf_addr has been stable for this whole cycle, so the read data
        // is valid at this edge.
        w_state_nxt     = S_OUT;
        w_dump_addr_nxt = r_index;
        w_dump_data_nxt = regf_rdata;
      end
      S_OUT: begin
        if (dump_ready) begin
          if (r_index == IDX_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RD;
            w_index_nxt = r_index + REGF_ADDR_W'(1);
          end
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_cycles     <= '0;
      r_timeout    <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_cycles     <= w_cycles_nxt;
      r_timeout    <= w_timeout_nxt;
      r_dump_addr  <= w_dump_addr_nxt;
      r_dump_data  <= w_dump_data_nxt;
      r_dump_valid <= (w_state_nxt == S_OUT);
      r_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_RD) || (w_state_nxt == S_OUT);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign regf_addr  = r_index;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign cycles     = r_cycles;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_xdump_ctrl.sv
// Self-checking bench for xdump_ctrl. Four instances run in lockstep on shared
// control inputs, each with its own parameter set:
//   0: CYC_W=32, TIMEOUT=0     1: CYC_W=32, TIMEOUT=100
//   2: CYC_W=32, TIMEOUT=10    3: CYC_W=4,  TIMEOUT=0
// Each instance reads the same combinational register-file model.
module tb_xdump_ctrl;
  localparam int N     = 4;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic rst, start, trap, dump_ready;
  logic [31:0] mem [WORDS];

  logic [N-1:0][3:0]  raddr;
  logic [N-1:0][31:0] rdata;
  logic [N-1:0]       dv, bsy, dn, tmo;
  logic [N-1:0][3:0]  daddr;
  logic [N-1:0][31:0] ddata;
  logic [N-1:0][31:0] cyc;
  logic [3:0]         cyc_d;

  int vectors = 0;
  int errs    = 0;

  logic [35:0] got [N][64];
  int          gotn [N];
  bit          pend [N];
  logic [3:0]  paddr [N];
  logic [31:0] pdata [N];

  always #5 clk = ~clk;

  assign cyc[3] = {28'd0, cyc_d};

  always_comb begin
    for (int k = 0; k < N; k++) rdata[k] = mem[raddr[k]];
  end

  xdump_ctrl #(.DATA_W(32), .REGF_ADDR_W(4), .CYC_W(32), .TIMEOUT(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .trap(trap), .regf_addr(raddr[0]), .regf_rdata(rdata[0]),
    .dump_valid(dv[0]), .dump_ready(dump_ready), .dump_addr(daddr[0]), .dump_data(ddata[0]),
    .cycles(cyc[0]), .busy(bsy[0]), .done(dn[0]), .timeout(tmo[0]));
  xdump_ctrl #(.DATA_W(32), .REGF_ADDR_W(4), .CYC_W(32), .TIMEOUT(100)) u_b (
    .clk(clk), .rst(rst), .start(start), .trap(trap), .regf_addr(raddr[1]), .regf_rdata(rdata[1]),
    .dump_valid(dv[1]), .dump_ready(dump_ready), .dump_addr(daddr[1]), .dump_data(ddata[1]),
    .cycles(cyc[1]), .busy(bsy[1]), .done(dn[1]), .timeout(tmo[1]));
  xdump_ctrl #(.DATA_W(32), .REGF_ADDR_W(4), .CYC_W(32), .TIMEOUT(10)) u_c (
    .clk(clk), .rst(rst), .start(start), .trap(trap), .regf_addr(raddr[2]), .regf_rdata(rdata[2]),
    .dump_valid(dv[2]), .dump_ready(dump_ready), .dump_addr(daddr[2]), .dump_data(ddata[2]),
    .cycles(cyc[2]), .busy(bsy[2]), .done(dn[2]), .timeout(tmo[2]));
  xdump_ctrl #(.DATA_W(32), .REGF_ADDR_W(4), .CYC_W(4), .TIMEOUT(0)) u_d (
    .clk(clk), .rst(rst), .start(start), .trap(trap), .regf_addr(raddr[3]), .regf_rdata(rdata[3]),
    .dump_valid(dv[3]), .dump_ready(dump_ready), .dump_addr(daddr[3]), .dump_data(ddata[3]),
    .cycles(cyc_d), .busy(bsy[3]), .done(dn[3]), .timeout(tmo[3]));

  function automatic int to_of(input int k);
    case (k)
      1:       return 100;
      2:       return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int cw_of(input int k);
    return (k == 3) ? 4 : 32;
  endfunction

  // Reference outcome of a run whose trap arrives after d non-trap RUN cycles:
  // returns {timeout, cycles}.
  function automatic logic [32:0] model(input int k, input int d);
    longint mx = (longint'(1) << cw_of(k)) - 1;
    longint dl = longint'(d);
    if (to_of(k) > 0 && to_of(k) - 1 < d) return {1'b1, 32'(to_of(k))};
    return {1'b0, 32'((dl > mx) ? mx : dl)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Log handshakes that the coming edge will complete, and remember offered
  // words that must stay stable.
  task automatic record();
    for (int k = 0; k < N; k++) begin
      if (rst && dv[k] && dump_ready) begin
        if (gotn[k] < 64) got[k][gotn[k]] = {daddr[k], ddata[k]};
        gotn[k]++;
        pend[k] = 1'b0;
      end else begin
        pend[k]  = rst && (dv[k] === 1'b1);
        paddr[k] = daddr[k];
        pdata[k] = ddata[k];
      end
    end
  endtask

  task automatic observe();
    for (int k = 0; k < N; k++) begin
      if (pend[k]) begin
        chk($sformatf("hold_valid[%0d]", k), {31'd0, dv[k]}, 32'd1);
        chk($sformatf("hold_addr[%0d]", k), {28'd0, daddr[k]}, {28'd0, paddr[k]});
        chk($sformatf("hold_data[%0d]", k), ddata[k], pdata[k]);
      end
    end
  endtask

  task automatic step();
    record();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_valid[%0d]", tag, k), {31'd0, dv[k]}, 32'd0);
      chk($sformatf("%s_busy[%0d]", tag, k), {31'd0, bsy[k]}, 32'd0);
      chk($sformatf("%s_done[%0d]", tag, k), {31'd0, dn[k]}, 32'd0);
      chk($sformatf("%s_tmo[%0d]", tag, k), {31'd0, tmo[k]}, 32'd0);
      chk($sformatf("%s_cyc[%0d]", tag, k), cyc[k], 32'd0);
      chk($sformatf("%s_daddr[%0d]", tag, k), {28'd0, daddr[k]}, 32'd0);
      chk($sformatf("%s_ddata[%0d]", tag, k), ddata[k], 32'd0);
      chk($sformatf("%s_raddr[%0d]", tag, k), {28'd0, raddr[k]}, 32'd0);
    end
  endtask

  // One complete run: start, d quiet RUN cycles, trap, then dump.
  // mode 0: ready always 1; 1: random ready; 2: ready low 5 cycles on word 3.
  task automatic run_once(input int d, input int mode);
    logic [32:0] m;
    int done_at;
    int held;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
    for (int k = 0; k < N; k++) gotn[k] = 0;
    start = 1'b1; trap = 1'b0; dump_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("start_cyc[%0d]", k), cyc[k], 32'd0);
      chk($sformatf("start_busy[%0d]", k), {31'd0, bsy[k]}, 32'd1);
      chk($sformatf("start_tmo[%0d]", k), {31'd0, tmo[k]}, 32'd0);
    end
    for (int i = 0; i < d; i++) step();
    for (int k = 0; k < N; k++) begin
      m = model(k, d);
      chk($sformatf("pretrap_cyc[%0d]", k), cyc[k], m[31:0]);
    end
    trap = 1'b1;
    step();
    done_at = -1;
    held = 0;
    for (int i = 0; i < 2000 && !(&dn); i++) begin
      trap = 1'($urandom_range(0, 1));
      dump_ready = 1'b1;
      if (mode == 1) dump_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && dv[0] && daddr[0] == 4'd3 && held < 5) begin
        dump_ready = 1'b0;
        held++;
      end
      step();
      if (done_at < 0 && dn[0]) done_at = i + 1;
    end
    trap = 1'b0; dump_ready = 1'b0;
    if (mode == 0) chk("done_latency", 32'(done_at), 32'd32);
    if (mode == 2) chk("bp_held", 32'(held), 32'd5);
    for (int k = 0; k < N; k++) begin
      m = model(k, d);
      chk($sformatf("cycles[%0d]", k), cyc[k], m[31:0]);
      chk($sformatf("timeout[%0d]", k), {31'd0, tmo[k]}, {31'd0, m[32]});
      chk($sformatf("done[%0d]", k), {31'd0, dn[k]}, 32'd1);
      chk($sformatf("end_busy[%0d]", k), {31'd0, bsy[k]}, 32'd0);
      chk($sformatf("end_valid[%0d]", k), {31'd0, dv[k]}, 32'd0);
      chk($sformatf("nwords[%0d]", k), 32'(gotn[k]), 32'd16);
      for (int i = 0; i < WORDS; i++) begin
        chk($sformatf("waddr[%0d][%0d]", k, i), {28'd0, got[k][i][35:32]}, 32'(i));
        chk($sformatf("wdata[%0d][%0d]", k, i), got[k][i][31:0], mem[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; trap = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
    for (int k = 0; k < N; k++) begin
      gotn[k] = 0; pend[k] = 1'b0;
    end
    step();
    step();
    check_reset("por");
    rst = 1'b1;
    // Trap and ready are ignored in IDLE; nothing may start without start.
    trap = 1'b1; dump_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int k = 0; k < N; k++) chk($sformatf("idle_busy[%0d]", k), {31'd0, bsy[k]}, 32'd0);
    end
    trap = 1'b0; dump_ready = 1'b0;

    run_once(25, 0);   // basic run
    run_once(30, 2);   // backpressure on word 3
    run_once(130, 0);  // watchdog on instance 1 (and 2)
    run_once(9, 0);    // trap coincides with TIMEOUT=10 limit
    run_once(20, 0);   // 4-bit counter saturates

    // Reset while instance 0 is offering word 7.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    trap = 1'b1; step(); trap = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 100 && !(dv[0] && daddr[0] == 4'd7); i++) step();
    chk("reach_word7", {31'd0, (dv[0] && daddr[0] == 4'd7)}, 32'd1);
    rst = 1'b0;
    step();
    check_reset("mid");
    rst = 1'b1; dump_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int k = 0; k < N; k++) chk($sformatf("postrst_busy[%0d]", k), {31'd0, bsy[k]}, 32'd0);
    end
    run_once(12, 0);

    for (int r = 0; r < 6; r++) run_once(int'($urandom_range(0, 140)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
